dmem_port_arbiter: RTL and testbench

//  Shares the single-port 4096x16 data memory between the CPU data port and a DMA/loader

---
 rtl/dmem_port_if.sv | 25 ++
 rtl/dmem_port_arbiter.sv | 146 ++++++++++++++
 tb/tb_dmem_port_arbiter.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_port_if.sv
// Requester-side bundle for one data-memory port (CPU or DMA).
// The arbiter takes the slave side; the requester drives the master side.
interface dmem_port_if #(
    parameter int AW = 12,
    parameter int DW = 16
);
    logic          req;
    logic          wr;
    logic          lock;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          gnt;
    logic          rvalid;
    logic [DW-1:0] rdata;

    modport master (
        output req, wr, lock, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, wr, lock, addr, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between CPU and DMA,
// with capped locked bursts and a registered one-beat read return per port.
module dmem_port_arbiter #(
    parameter int AW        = 12,
    parameter int DW        = 16,
    parameter int MAX_BURST = 8,
    parameter int CPU_FIRST = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    dmem_port_if.slave    cpu,
    dmem_port_if.slave    dma,
    output logic          mem_rd,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wd,
    input  logic [DW-1:0] mem_rdata
);

    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BURST);
    localparam logic LAST_RST = (CPU_FIRST != 0);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOCK_CPU = 2'd1,
        LOCK_DMA = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] burst_cnt_q, burst_cnt_d;
    // 1 = DMA won most recently, 0 = CPU
    logic          last_q, last_d;
    logic          c_rvalid_q, c_rvalid_d;
    logic          d_rvalid_q, d_rvalid_d;
    logic [DW-1:0] c_rdata_q, c_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;

    logic          capped;
    logic          c_keep, d_keep;
    logic          win_c, win_d;
    logic [CW-1:0] cnt_inc;

    always_comb begin
        capped = (burst_cnt_q == MAX_CNT);
        c_keep = (state_q == LOCK_CPU) && cpu.req
                 && !(capped && dma.req);
        d_keep = (state_q == LOCK_DMA) && dma.req
                 && !(capped && cpu.req);
        // A capped owner loses the tie because it is last_q
        win_c  = rst_n && (c_keep || (!d_keep && cpu.req
                 && (!dma.req || last_q)));
        win_d  = rst_n && !win_c && dma.req;
        cnt_inc = capped ? burst_cnt_q : burst_cnt_q + 1'b1;
    end

    always_comb begin
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        mem_addr = '0;
        mem_wd   = '0;
        if (win_c) begin
            mem_rd   = !cpu.wr;
            mem_wr   = cpu.wr;
            mem_addr = cpu.addr;
            mem_wd   = cpu.wdata;
        end else if (win_d) begin
            mem_rd   = !dma.wr;
            mem_wr   = dma.wr;
            mem_addr = dma.addr;
            mem_wd   = dma.wdata;
        end
    end

    always_comb begin
        state_d     = state_q;
        burst_cnt_d = burst_cnt_q;
        last_d      = last_q;
        unique case (1'b1)
            win_c: begin
                last_d = 1'b0;
                if (cpu.lock) begin
                    state_d     = LOCK_CPU;
                    burst_cnt_d = (state_q == LOCK_CPU)
                                  ? cnt_inc : CW'(1);
                end else begin
                    state_d     = IDLE;
                    burst_cnt_d = '0;
                end
            end
            win_d: begin
                last_d = 1'b1;
                if (dma.lock) begin
                    state_d     = LOCK_DMA;
                    burst_cnt_d = (state_q == LOCK_DMA)
                                  ? cnt_inc : CW'(1);
                end else begin
                    state_d     = IDLE;
                    burst_cnt_d = '0;
                end
            end
            default: begin
                // No grant means the lock owner has let go
                if (state_q != IDLE) begin
                    state_d     = IDLE;
                    burst_cnt_d = '0;
                end
            end
        endcase
    end

    always_comb begin
        c_rvalid_d = win_c && !cpu.wr;
        d_rvalid_d = win_d && !dma.wr;
        c_rdata_d  = c_rvalid_d ? mem_rdata : c_rdata_q;
        d_rdata_d  = d_rvalid_d ? mem_rdata : d_rdata_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            burst_cnt_q <= '0;
            last_q      <= LAST_RST;
            c_rvalid_q  <= 1'b0;
            d_rvalid_q  <= 1'b0;
            c_rdata_q   <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            burst_cnt_q <= burst_cnt_d;
            last_q      <= last_d;
            c_rvalid_q  <= c_rvalid_d;
            d_rvalid_q  <= d_rvalid_d;
            c_rdata_q   <= c_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign cpu.gnt    = win_c;
    assign dma.gnt    = win_d;
    assign cpu.rvalid = c_rvalid_q;
    assign dma.rvalid = d_rvalid_q;
    assign cpu.rdata  = c_rdata_q;
    assign dma.rdata  = d_rdata_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a behavioural 4096x16 memory.
module tb_dmem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_rd, mem_wr;
    logic [11:0] mem_addr;
    logic [15:0] mem_wd, mem_rdata;

    logic [15:0] mem [4096];
    logic        pl_we;
    logic [11:0] pl_addr;
    logic [15:0] pl_data;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    dmem_port_if #(.AW(12), .DW(16)) cpu_if ();
    dmem_port_if #(.AW(12), .DW(16)) dma_if ();

    dmem_port_arbiter #(
        .AW(12), .DW(16), .MAX_BURST(8), .CPU_FIRST(1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cpu      (cpu_if),
        .dma      (dma_if),
        .mem_rd   (mem_rd),
        .mem_wr   (mem_wr),
        .mem_addr (mem_addr),
        .mem_wd   (mem_wd),
        .mem_rdata(mem_rdata)
    );

    always @(posedge clk) begin
        if (pl_we) mem[pl_addr] <= pl_data;
        else if (mem_wr) mem[mem_addr] <= mem_wd;
    end

    assign mem_rdata = mem_rd ? mem[mem_addr] : 16'h0;

    typedef struct packed {
        logic        cr, cw, cl;
        logic [11:0] ca;
        logic [15:0] cd;
        logic        dr, dw, dl;
        logic [11:0] da;
        logic [15:0] dd;
        logic        cg, dg, crv, drv;
        logic [15:0] crd, drd;
        logic        mrd, mwr;
        logic [11:0] maddr;
    } vec_t;

    vec_t v [15];

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    task automatic drv_cpu(input logic r, input logic w,
                           input logic l, input logic [11:0] a,
                           input logic [15:0] d);
        cpu_if.req = r; cpu_if.wr = w; cpu_if.lock = l;
        cpu_if.addr = a; cpu_if.wdata = d;
    endtask

    task automatic drv_dma(input logic r, input logic w,
                           input logic l, input logic [11:0] a,
                           input logic [15:0] d);
        dma_if.req = r; dma_if.wr = w; dma_if.lock = l;
        dma_if.addr = a; dma_if.wdata = d;
    endtask

    task automatic idle();
        drv_cpu(0, 0, 0, 0, 0);
        drv_dma(0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        idle();
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic preload(input logic [11:0] a,
                           input logic [15:0] d);
        @(posedge clk); #1;
        pl_we = 1'b1; pl_addr = a; pl_data = d;
        @(posedge clk); #1;
        pl_we = 1'b0;
    endtask

    initial begin
        int beats;
        logic cdone;
        pl_we = 1'b0; pl_addr = '0; pl_data = '0;
        rst_n = 1'b0;
        idle();

        v[0]  = '{0,0,0,12'h000,16'h0, 0,0,0,12'h000,16'h0,
                  0,0,0,0,16'h0000,16'h0000,0,0,12'h000};
        v[1]  = '{1,0,0,12'h001,16'h0, 0,0,0,12'h000,16'h0,
                  1,0,0,0,16'h0000,16'h0000,1,0,12'h001};
        v[2]  = '{0,0,0,12'h000,16'h0, 0,0,0,12'h000,16'h0,
                  0,0,1,0,16'h0008,16'h0000,0,0,12'h000};
        v[3]  = '{1,0,0,12'h000,16'h0, 1,0,0,12'h001,16'h0,
                  0,1,0,0,16'h0008,16'h0000,1,0,12'h001};
        v[4]  = '{1,0,0,12'h000,16'h0, 1,0,0,12'h000,16'h0,
                  1,0,0,1,16'h0008,16'h0008,1,0,12'h000};
        v[5]  = '{1,0,0,12'h001,16'h0, 1,0,0,12'h000,16'h0,
                  0,1,1,0,16'h0002,16'h0008,1,0,12'h000};
        v[6]  = '{1,0,0,12'h001,16'h0, 1,0,0,12'h001,16'h0,
                  1,0,0,1,16'h0002,16'h0002,1,0,12'h001};
        v[7]  = '{1,0,0,12'h000,16'h0, 1,0,0,12'h001,16'h0,
                  0,1,1,0,16'h0008,16'h0002,1,0,12'h001};
        v[8]  = '{0,0,0,12'h000,16'h0, 0,0,0,12'h000,16'h0,
                  0,0,0,1,16'h0008,16'h0008,0,0,12'h000};
        v[9]  = '{1,1,0,12'hfff,16'habcd, 0,0,0,12'h000,16'h0,
                  1,0,0,0,16'h0008,16'h0008,0,1,12'hfff};
        v[10] = '{0,0,0,12'h000,16'h0, 1,0,0,12'hfff,16'h0,
                  0,1,0,0,16'h0008,16'h0008,1,0,12'hfff};
        v[11] = '{0,0,0,12'h000,16'h0, 0,0,0,12'h000,16'h0,
                  0,0,0,1,16'h0008,16'habcd,0,0,12'h000};
        v[12] = '{0,0,0,12'h000,16'h0, 1,1,0,12'h005,16'h1234,
                  0,1,0,0,16'h0008,16'habcd,0,1,12'h005};
        v[13] = '{1,0,0,12'h005,16'h0, 0,0,0,12'h000,16'h0,
                  1,0,0,0,16'h0008,16'habcd,1,0,12'h005};
        v[14] = '{0,0,0,12'h000,16'h0, 0,0,0,12'h000,16'h0,
                  0,0,1,0,16'h1234,16'habcd,0,0,12'h000};

        #2;
        chk("rst cg", 32'(cpu_if.gnt), 0);
        chk("rst crv", 32'(cpu_if.rvalid), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        preload(12'h000, 16'h0002);
        preload(12'h001, 16'h0008);

        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            drv_cpu(v[i].cr, v[i].cw, v[i].cl, v[i].ca, v[i].cd);
            drv_dma(v[i].dr, v[i].dw, v[i].dl, v[i].da, v[i].dd);
            @(negedge clk);
            chk($sformatf("r%0d cg", i), 32'(cpu_if.gnt), 32'(v[i].cg));
            chk($sformatf("r%0d dg", i), 32'(dma_if.gnt), 32'(v[i].dg));
            chk($sformatf("r%0d crv", i), 32'(cpu_if.rvalid), 32'(v[i].crv));
            chk($sformatf("r%0d drv", i), 32'(dma_if.rvalid), 32'(v[i].drv));
            chk($sformatf("r%0d crd", i), 32'(cpu_if.rdata), 32'(v[i].crd));
            chk($sformatf("r%0d drd", i), 32'(dma_if.rdata), 32'(v[i].drd));
            chk($sformatf("r%0d mrd", i), 32'(mem_rd), 32'(v[i].mrd));
            chk($sformatf("r%0d mwr", i), 32'(mem_wr), 32'(v[i].mwr));
            chk($sformatf("r%0d ma", i), 32'(mem_addr), 32'(v[i].maddr));
        end

        // Locked DMA burst capped at 8 while CPU waits
        do_reset();
        beats = 0;
        cdone = 1'b0;
        for (int c = 1; c <= 11; c++) begin
            @(posedge clk); #1;
            drv_dma(1, 1, 1, 12'(12'h100 + beats), 16'(16'hd000 + beats));
            drv_cpu((c >= 2) && !cdone, 0, 0, 12'h000, 0);
            @(negedge clk);
            chk($sformatf("b%0d cg", c), 32'(cpu_if.gnt),
                32'(c == 9));
            chk($sformatf("b%0d dg", c), 32'(dma_if.gnt),
                32'(c <= 8 || c >= 10));
            if (c == 10) begin
                chk("b crv", 32'(cpu_if.rvalid), 1);
                chk("b crd", 32'(cpu_if.rdata), 32'h0002);
            end
            if (cpu_if.gnt) cdone = 1'b1;
            if (dma_if.gnt) beats++;
        end
        @(posedge clk); #1;
        idle();
        @(posedge clk); #1;
        chk("b m100", 32'(mem[12'h100]), 32'hd000);
        chk("b m107", 32'(mem[12'h107]), 32'hd007);
        chk("b m109", 32'(mem[12'h109]), 32'hd009);
        chk("b m000", 32'(mem[12'h000]), 32'h0002);

        // Asynchronous reset in the middle of a locked CPU burst
        do_reset();
        @(posedge clk); #1;
        drv_cpu(1, 0, 1, 12'h001, 0);
        @(negedge clk);
        chk("r5 cg1", 32'(cpu_if.gnt), 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("r5 crv", 32'(cpu_if.rvalid), 1);
        chk("r5 crd", 32'(cpu_if.rdata), 32'h0008);
        #2;
        rst_n = 1'b0;
        #1;
        chk("r5 rst cg", 32'(cpu_if.gnt), 0);
        chk("r5 rst crv", 32'(cpu_if.rvalid), 0);
        chk("r5 rst crd", 32'(cpu_if.rdata), 0);
        chk("r5 rst mrd", 32'(mem_rd), 0);
        chk("r5 rst ma", 32'(mem_addr), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        drv_cpu(1, 0, 0, 12'h000, 0);
        drv_dma(1, 0, 0, 12'h001, 0);
        @(negedge clk);
        chk("r5 tie cg", 32'(cpu_if.gnt), 1);
        chk("r5 tie dg", 32'(dma_if.gnt), 0);

        // Locked CPU lets go while DMA waits
        do_reset();
        @(posedge clk); #1;
        drv_cpu(1, 0, 1, 12'h000, 0);
        @(negedge clk);
        chk("l6 cg", 32'(cpu_if.gnt), 1);
        @(posedge clk); #1;
        drv_cpu(0, 0, 0, 12'h000, 0);
        drv_dma(1, 0, 0, 12'h001, 0);
        @(negedge clk);
        chk("l6 dg", 32'(dma_if.gnt), 1);
        chk("l6 cg0", 32'(cpu_if.gnt), 0);
        chk("l6 crd", 32'(cpu_if.rdata), 32'h0002);
        @(posedge clk); #1;
        drv_cpu(1, 0, 0, 12'h000, 0);
        drv_dma(1, 0, 0, 12'h000, 0);
        @(negedge clk);
        chk("l6 st", 32'(dut.state_q), 0);
        chk("l6 cnt", 32'(dut.burst_cnt_q), 0);
        chk("l6 tie cg", 32'(cpu_if.gnt), 1);
        chk("l6 drd", 32'(dma_if.rdata), 32'h0008);
        @(posedge clk); #1;
        idle();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
